// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding UartTx through its we/ready handshake; bursts drain one byte per strobe.
// Optional sticky overflow flag enabled by defining UART_TXQ_OVF_EN.
module uart_tx_queue #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            DIN,
  input  logic                  ENQ,
  output logic                  FULL,
  output logic [ADDR_WIDTH:0]   COUNT,
  output logic [7:0]            TX_DATA,
  output logic                  TX_WE,
  input  logic                  TX_READY,
  output logic                  OVF
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [7:0]            mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic [ADDR_WIDTH:0]   count_q, count_n;
  logic                  full_q;
  logic [7:0]            tx_data_q;
  logic                  tx_we_q;
  logic                  enq_ok, deq;

  // The !tx_we_q term covers the cycle before UartTx has dropped ready after our strobe.
  always_comb begin
    enq_ok  = ENQ && !full_q;
    deq     = (count_q != '0) && TX_READY && !tx_we_q;
    count_n = count_q;
    if (enq_ok && !deq) begin
      count_n = count_q + (ADDR_WIDTH+1)'(1);
    end else if (deq && !enq_ok) begin
      count_n = count_q - (ADDR_WIDTH+1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (enq_ok) begin
      mem[wptr] <= DIN;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr      <= '0;
      rptr      <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      tx_data_q <= '0;
      tx_we_q   <= 1'b0;
    end else begin
      if (enq_ok) begin
        wptr <= wptr + ADDR_WIDTH'(1);
      end
      if (deq) begin
        tx_data_q <= mem[rptr];
        rptr      <= rptr + ADDR_WIDTH'(1);
        tx_we_q   <= 1'b1;
      end else begin
        tx_we_q   <= 1'b0;
      end
      count_q <= count_n;
      full_q  <= (count_n == (ADDR_WIDTH+1)'(DEPTH));
    end
  end

`ifdef UART_TXQ_OVF_EN
  logic ovf_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ovf_q <= 1'b0;
    end else if (ENQ && full_q) begin
      ovf_q <= 1'b1;
    end
  end

  assign OVF = ovf_q;
`else
  assign OVF = 1'b0;
`endif

  assign FULL    = full_q;
  assign COUNT   = count_q;
  assign TX_DATA = tx_data_q;
  assign TX_WE   = tx_we_q;

endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Byte FIFO placed directly upstream of `UartTx`. Producers push bytes at full clock rate; the queue drains them into the transmitter one at a time using `UartTx`'s `we`/`ready` handshake. This lets a producer send bursts longer than one frame time without the per-byte `ready` polling done in `main`.

## Interface
Parameters:
- `ADDR_WIDTH`, default 4: log2 of the queue depth (default depth 16 bytes).

Ports:
- `CLK`  in  1  clock; the same clock as `UartTx`.
- `RST`  in  1  asynchronous, active-high reset.
- `DIN`  in  8  byte to enqueue.
- `ENQ`  in  1  enqueue strobe; `DIN` is sampled on the same edge.
- `FULL`  out  1  queue holds 2^ADDR_WIDTH bytes.
- `COUNT`  out  ADDR_WIDTH+1  current occupancy, 0..2^ADDR_WIDTH.
- `TX_DATA`  out  8  byte presented to `UartTx` data input.
- `TX_WE`  out  1  one-cycle write strobe to `UartTx` `we`.
- `TX_READY`  in  1  `UartTx` `ready`.
- `OVF`  out  1  sticky overflow flag (see Configuration).

## Operation
- Storage: 2^ADDR_WIDTH x 8 register array, ADDR_WIDTH-bit write/read pointers, ADDR_WIDTH+1-bit count. Pointers wrap modulo depth with no special casing.
- Enqueue is accepted when `ENQ && !FULL`. The byte is written at `wptr`, then `wptr` increments.
- `ENQ` while `FULL` drops the byte. No pointer or count change occurs, even if a dequeue happens in the same cycle. `FULL` is the registered state at the start of the cycle.
- A dequeue fires when `COUNT != 0 && TX_READY && !TX_WE`. On that edge:
  - `TX_DATA <= mem[rptr]`
  - `TX_WE <= 1`
  - `rptr` increments.
- The `!TX_WE` guard covers the one cycle in which `UartTx` has not yet dropped `ready`. It guarantees at most one strobe per two cycles.
- `TX_WE` is high for exactly one cycle per dequeue. `TX_DATA` holds its value until the next dequeue.
- Count update:
  - enqueue only: +1
  - dequeue only: -1
  - both in the same cycle: unchanged
- Simultaneous enqueue and dequeue with `COUNT==1` is legal. The read uses the old entry and the new byte lands in the next slot.
- Order is strict FIFO with no byte duplication.

## Timing
- Reset values: `FULL=0`, `COUNT=0`, `TX_DATA=8'h00`, `TX_WE=0`, `OVF=0`, both pointers 0. Memory contents are not reset.
- Asserting `RST` mid-operation empties the queue immediately and deasserts `TX_WE` asynchronously. A frame already latched by `UartTx` is not affected.
- Latency, empty queue with `TX_READY=1`: enqueue on edge k gives `TX_WE` high after edge k+1 (2 cycles from `ENQ` to strobe).
- With `TX_READY` held high, the drain rate is one byte every 2 cycles. In practice the rate is bounded by `UartTx` frame time.
- `FULL` and `COUNT` are registered and reflect the state after the previous edge. `FULL` is equivalent to `COUNT == 2^ADDR_WIDTH`.

## Configuration
- Macro: `UART_TXQ_OVF_EN`.
- When defined:
  - `OVF` is set on any cycle with `ENQ && FULL`.
  - `OVF` stays set until `RST`.
- When undefined:
  - `OVF` is tied to 0.
  - No overflow logic is synthesized.
  - Drop behaviour is unchanged.

## Test plan
- **Reset, then idle 20 cycles with `TX_READY=1`**: `TX_WE` stays 0, `COUNT=0`, `FULL=0`, `TX_DATA=8'h00`.
- **Single byte, `TX_READY=1`**: enqueue `8'h61` at edge k. `TX_WE=1` with `TX_DATA=8'h61` after edge k+1, for exactly one cycle. `COUNT` goes 0→1→0.
- **Burst into a real `UartTx`**: enqueue `8'h61..8'h64` on consecutive cycles. `COUNT` peaks at 4 or less. A loopback `UartRx` receives `61,62,63,64` in order. Exactly 4 `TX_WE` pulses, each only while `TX_READY=1`.
- **Fill and overflow, `TX_READY=0`, default depth**:
  - Enqueue 17 bytes `8'h00..8'h10`. `FULL=1` after 16. Byte `8'h10` is dropped.
  - With `UART_TXQ_OVF_EN`: `OVF=1`. Without it: `OVF=0`.
  - Release `TX_READY`: bytes `00..0F` come out in order.
- **Simultaneous enqueue and dequeue, `COUNT=1`**: holding `8'hA0`, enqueue `8'hA1` on the dequeue edge. `TX_DATA=8'hA0`, `COUNT` remains 1, and the next strobe carries `8'hA1`.
- **Reset mid-burst**: assert `RST` with `COUNT=5`. Asynchronously, `COUNT=0` and `TX_WE=0`. After release, with no new `ENQ`, no `TX_WE` pulses occur.
